// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor (bimodal or gshare) with mispredict/flush generation and perf counters.
// Latency: prediction and flush are combinational; table, history and counter updates land at the next edge.
// Backpressure: none; the pipeline holds ex_valid low on bubbles/stalls so each branch resolves once.
module branch_predict_unit #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int GHR_W  = 6,
    parameter int GSHARE = 1,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [IDX_W-1:0]  if_pred_idx,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jalr,
    input  logic              ex_pred_taken,
    input  logic [IDX_W-1:0]  ex_pred_idx,
    input  logic              ex_actual_taken,
    output logic              flush,
    output logic              mispredict,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] pht [DEPTH];
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] fetch_idx;
    logic             resolve;
    logic             unused_pc_bits;

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign pc_idx         = if_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

    generate
        if (GSHARE != 0) begin : g_gshare
            assign fetch_idx = pc_idx ^ IDX_W'(ghr);
        end else begin : g_bimodal
            assign fetch_idx = pc_idx;
        end
    endgenerate

    // Read is of the registered table: a same-cycle update is not bypassed.
    assign if_pred_idx   = fetch_idx;
    assign if_pred_taken = pht[fetch_idx][CNT_W-1];

    assign resolve    = ex_valid & ex_is_branch;
    assign mispredict = resolve & (ex_pred_taken != ex_actual_taken);
    assign flush      = mispredict | (ex_valid & ex_is_jalr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr              <= '0;
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (resolve) begin
                // Update the entry that produced the prediction, not today's fetch index.
                if (ex_actual_taken) begin
                    if (pht[ex_pred_idx] != CNT_MAX) begin
                        pht[ex_pred_idx] <= pht[ex_pred_idx] + CNT_W'(1);
                    end
                end else begin
                    if (pht[ex_pred_idx] != '0) begin
                        pht[ex_pred_idx] <= pht[ex_pred_idx] - CNT_W'(1);
                    end
                end
                ghr           <= GHR_W'({ghr, ex_actual_taken});
                perf_branches <= perf_branches + PERF_W'(1);
            end
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: bimodal, gshare and a 4-bit perf-counter instance share stimulus.
// Vector table covers prediction/update/flush; hand sequences cover async reset, gshare indexing and wrap.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        ex_valid, ex_is_branch, ex_is_jalr, ex_pred_taken, ex_actual_taken;
    logic [5:0]  ex_pred_idx;

    logic        b_pt, b_flush, b_mis;
    logic [5:0]  b_idx;
    logic [31:0] b_pb, b_pm;
    logic        g_pt, g_flush, g_mis;
    logic [5:0]  g_idx;
    logic [31:0] g_pb, g_pm;
    logic        p_pt, p_flush, p_mis;
    logic [5:0]  p_idx;
    logic [3:0]  p_pb, p_pm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.GSHARE(0)) u_bim (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(b_pt), .if_pred_idx(b_idx),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx), .ex_actual_taken(ex_actual_taken),
        .flush(b_flush), .mispredict(b_mis), .perf_branches(b_pb), .perf_mispredicts(b_pm));

    branch_predict_unit #(.GSHARE(1)) u_gsh (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(g_pt), .if_pred_idx(g_idx),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx), .ex_actual_taken(ex_actual_taken),
        .flush(g_flush), .mispredict(g_mis), .perf_branches(g_pb), .perf_mispredicts(g_pm));

    branch_predict_unit #(.GSHARE(0), .PERF_W(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(p_pt), .if_pred_idx(p_idx),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_idx(ex_pred_idx), .ex_actual_taken(ex_actual_taken),
        .flush(p_flush), .mispredict(p_mis), .perf_branches(p_pb), .perf_mispredicts(p_pm));

    typedef struct {
        logic [31:0] pc;
        int v, br, jr, pt, pi, at;
        int e_pt, e_idx, e_fl, e_mis, e_pb, e_pm, e_pht;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input int v, input int br, input int jr,
                         input int pt, input int pi, input int at);
        if_pc           = pc;
        ex_valid        = 1'(v);
        ex_is_branch    = 1'(br);
        ex_is_jalr      = 1'(jr);
        ex_pred_taken   = 1'(pt);
        ex_pred_idx     = 6'(pi);
        ex_actual_taken = 1'(at);
    endtask

    initial begin
        int bad;
        // pc, v, br, jr, pt, pi, at | pred, idx, flush, mis, branches, mispredicts, PHT[16] before edge
        tbl[0]  = '{32'h40,  0, 0, 0, 0, 0,  0,  0, 16, 0, 0, 0, 0, 1};
        tbl[1]  = '{32'h40,  1, 1, 0, 0, 16, 1,  0, 16, 1, 1, 0, 0, 1};
        tbl[2]  = '{32'h40,  1, 1, 0, 1, 16, 1,  1, 16, 0, 0, 1, 1, 2};
        tbl[3]  = '{32'h40,  1, 1, 0, 1, 16, 1,  1, 16, 0, 0, 2, 1, 3};
        tbl[4]  = '{32'h44,  0, 0, 0, 0, 0,  0,  0, 17, 0, 0, 3, 1, 3};
        tbl[5]  = '{32'h44,  1, 0, 1, 0, 17, 1,  0, 17, 1, 0, 3, 1, 3};
        tbl[6]  = '{32'h44,  0, 1, 1, 0, 17, 1,  0, 17, 0, 0, 3, 1, 3};
        tbl[7]  = '{32'h44,  0, 0, 0, 0, 0,  0,  0, 17, 0, 0, 3, 1, 3};
        tbl[8]  = '{32'h143, 0, 0, 0, 0, 0,  0,  1, 16, 0, 0, 3, 1, 3};
        tbl[9]  = '{32'h40,  1, 1, 0, 1, 16, 0,  1, 16, 1, 1, 3, 1, 3};
        tbl[10] = '{32'h40,  0, 0, 0, 0, 0,  0,  1, 16, 0, 0, 4, 2, 2};
        tbl[11] = '{32'h40,  1, 1, 0, 1, 16, 0,  1, 16, 1, 1, 4, 2, 2};
        tbl[12] = '{32'h40,  0, 0, 0, 0, 0,  0,  0, 16, 0, 0, 5, 3, 1};

        rst_n = 1'b1;
        drive(32'h40, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #11;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (u_bim.pht[i] !== 2'b01) bad++;
        end
        check("reset_pht_all_01", 32'(bad), 32'd0);
        check("reset_idx", 32'(b_idx), 32'd16);
        check("reset_pred", 32'(b_pt), 32'd0);
        check("reset_flush", 32'(b_flush), 32'd0);
        check("reset_ghr", 32'(u_gsh.ghr), 32'd0);
        check("reset_perf_br", b_pb, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].pc, tbl[i].v, tbl[i].br, tbl[i].jr, tbl[i].pt, tbl[i].pi, tbl[i].at);
            #1;
            check($sformatf("v%0d_pred", i), 32'(b_pt), 32'(tbl[i].e_pt));
            check($sformatf("v%0d_idx", i), 32'(b_idx), 32'(tbl[i].e_idx));
            check($sformatf("v%0d_flush", i), 32'(b_flush), 32'(tbl[i].e_fl));
            check($sformatf("v%0d_mispredict", i), 32'(b_mis), 32'(tbl[i].e_mis));
            check($sformatf("v%0d_perf_br", i), b_pb, 32'(tbl[i].e_pb));
            check($sformatf("v%0d_perf_mis", i), b_pm, 32'(tbl[i].e_pm));
            check($sformatf("v%0d_pht16", i), 32'(u_bim.pht[16]), 32'(tbl[i].e_pht));
        end

        // Drive PHT[16] back to strongly taken, then reset between edges.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) drive(32'h40, 1, 1, 0, 1, 16, 1);
        end
        @(negedge clk) drive(32'h40, 0, 0, 0, 0, 0, 0);
        #2;
        check("pre_reset_pht16", 32'(u_bim.pht[16]), 32'd3);
        check("pre_reset_perf_br", b_pb, 32'd7);
        rst_n = 1'b0;
        #1;
        check("async_reset_pht16", 32'(u_bim.pht[16]), 32'd1);
        check("async_reset_perf_br", b_pb, 32'd0);
        check("async_reset_perf_mis", b_pm, 32'd0);
        check("async_reset_ghr", 32'(u_gsh.ghr), 32'd0);
        check("async_reset_pred", 32'(b_pt), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Gshare history: taken, taken, not-taken.
        @(negedge clk) drive(32'h0, 1, 1, 0, 0, 0, 1);
        @(negedge clk) drive(32'h0, 1, 1, 0, 0, 0, 1);
        @(negedge clk) drive(32'h0, 1, 1, 0, 0, 0, 0);
        @(negedge clk) drive(32'h40, 0, 0, 0, 0, 0, 0);
        #1;
        check("gshare_ghr", 32'(u_gsh.ghr), 32'd6);
        check("gshare_idx", 32'(g_idx), 32'd22);
        check("gshare_pred", 32'(g_pt), 32'd0);
        check("bimodal_idx_ignores_ghr", 32'(b_idx), 32'd16);
        // Update the carried index 22; the history moves to 001101 so pc 0x6C maps back to 22.
        @(negedge clk) drive(32'h40, 1, 1, 0, 0, 22, 1);
        #1 check("gshare_same_cycle_old", 32'(g_pt), 32'd0);
        @(negedge clk) drive(32'h6C, 0, 0, 0, 0, 0, 0);
        #1;
        check("gshare_ghr2", 32'(u_gsh.ghr), 32'd13);
        check("gshare_idx2", 32'(g_idx), 32'd22);
        check("gshare_carried_update", 32'(g_pt), 32'd1);

        // Perf counter wrap on the 4-bit instance.
        @(negedge clk) rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk) drive(32'h14, 1, 1, 0, 0, 5, 1);
            if (i == 15) begin
                #1 check("p4_perf_br_15", 32'(p_pb), 32'd15);
            end
        end
        @(negedge clk) drive(32'h14, 0, 0, 0, 0, 0, 0);
        #1;
        check("p4_perf_br_wrap", 32'(p_pb), 32'd0);
        check("p4_perf_mis_wrap", 32'(p_pm), 32'd0);
        check("p32_perf_br_16", b_pb, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised dynamic branch predictor with mispredict/flush generator for the 5-stage RV32I pipeline.
- Fetch stage: reads a table of saturating counters and outputs a taken/not-taken prediction plus the table index used.
- Execute stage: the resolved outcome updates the table and global history; a flush is raised on mispredict or a JALR redirect.
- Counts resolved branches and mispredicts for performance analysis.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 6, PHT index width; table depth = 2**IDX_W.
- CNT_W, 2, saturating counter width (1..4).
- GHR_W, 6, global history length (1..IDX_W); used only when GSHARE=1.
- GSHARE, 1, 1 = gshare index (PC xor GHR), 0 = bimodal (PC only).
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_W  fetch PC
- if_pred_taken  out  1  prediction for if_pc
- if_pred_idx  out  IDX_W  table index used; carried down the pipeline with the instruction
- ex_valid  in  1  execute-stage instruction valid (not a bubble)
- ex_is_branch  in  1  instruction is a B-type branch
- ex_is_jalr  in  1  instruction is a JALR
- ex_pred_taken  in  1  prediction carried from fetch
- ex_pred_idx  in  IDX_W  index carried from fetch
- ex_actual_taken  in  1  branch outcome from branch comparator
- flush  out  1  kill IF/ID contents and redirect PC
- mispredict  out  1  flush caused by a branch mismatch
- perf_branches  out  PERF_W  resolved branch count
- perf_mispredicts  out  PERF_W  mispredicted branch count

Behaviour:
- Index: GSHARE=1 -> idx = if_pc[IDX_W+1:2] xor zero-extended GHR; GSHARE=0 -> idx = if_pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Prediction: combinational. if_pred_taken = MSB of PHT[idx]; if_pred_idx = idx.
- Resolve event: ex_valid & ex_is_branch.
- On a resolve event, at the clock edge:
  - PHT[ex_pred_idx] increments if ex_actual_taken, decrements otherwise, saturating at 0 and 2**CNT_W-1.
  - GHR <= {GHR[GHR_W-2:0], ex_actual_taken}; GHR is non-speculative and changes only on resolve.
  - perf_branches += 1.
- The update always uses the carried ex_pred_idx, never a recomputed index.
- mispredict = ex_valid & ex_is_branch & (ex_pred_taken != ex_actual_taken). Combinational, same cycle.
- flush = mispredict | (ex_valid & ex_is_jalr). JALR always flushes because its target is unknown at fetch.
- perf_mispredicts += 1 at the edge when mispredict=1.
- Both perf counters wrap at 2**PERF_W, with no saturation.
- ex_is_branch and ex_is_jalr both set is illegal; branch behaviour takes priority.
- ex_valid=0: no update, no flush, no count, regardless of the other ex_* inputs.
- Same-cycle read/write to the same index: the fetch read returns the pre-update (old) value, with no bypass. The new value is visible in the next cycle.
- Reset (rst_n low, asynchronous, any time including mid-update):
  - every PHT entry = 2**(CNT_W-1)-1 (weakly not-taken; 2'b01 for CNT_W=2)
  - GHR = 0
  - perf counters = 0
  - flush, mispredict and if_pred_taken follow combinationally from the reset state (0 when ex_valid=0).
- Storage: flops, not RAM. This is required for async reset of the whole table.
- No internal stall input. The pipeline holds ex_valid low on bubbles and stalls, so each execute instruction resolves exactly once.

Test Plan:
- Reset, then if_pc=0x0000_0040, GSHARE=0 -> if_pred_idx=16, if_pred_taken=0. Counter reads 2'b01 for every idx 0..63.
- Bimodal, 3 taken branches at pc 0x40, each with ex_valid=1 and the correct carried idx=16 -> PHT[16] goes 01->10->11->11 (saturates). if_pred_taken=1 after the first update. perf_branches=3. perf_mispredicts=1 (first branch predicted 0, actual 1), and flush was high only on that cycle.
- Same-cycle hazard: resolve taken at idx 16 while if_pc=0x40 -> if_pred_taken still shows the old MSB that cycle and the new value the next cycle.
- Gshare, GHR_W=6: resolve taken, taken, not-taken -> GHR=6'b000110. Then if_pc=0x40 -> if_pred_idx = 16 xor 6 = 22.
- ex_valid=1, ex_is_jalr=1, ex_is_branch=0 -> flush=1, mispredict=0, no PHT/GHR/perf change. Same inputs with ex_valid=0 -> flush=0.
- Assert rst_n low mid-sequence (PHT[16]=11, perf counters nonzero) -> immediately, without waiting for a clock edge, PHT[16]=01, GHR=0, perf counters=0. Force PERF_W=4 and run 16 branches -> perf_branches wraps to 0.
